fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
- Controls a single-port unified memory shared by instruction fetch (IF stage) and data access (MEM stage).
- Arbitrates and sequences requests over a req/ack memory handshake with variable latency.
- Generates freeze for the IF stage and the MEM-stage stall.
- Handles a branch redirect while a fetch is in flight by squashing the stale instruction.

Parameters:
- WORD_LEN, 32, data/address width (matches the `WORD_LEN define).
- STARVE_MAX, 2, consecutive data grants made while a fetch waits before the fetch is forced to win the next grant.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- ifAddr  input  WORD_LEN  PC to fetch, held stable while ifFreeze=1.
- brTaken  input  1  branch redirect from EX; may assert in any cycle.
- dReq  input  1  data access request, level, held until dDone.
- dWe  input  1  1=store, 0=load; valid with dReq.
- dAddr  input  WORD_LEN  data address.
- dWdata  input  WORD_LEN  store data.
- memAck  input  1  memory completes current access; one-cycle pulse.
- memRdata  input  WORD_LEN  read data, valid when memAck=1.
- memReq  output  1  memory request, held until memAck.
- memWe  output  1  write enable, valid with memReq.
- memAddr  output  WORD_LEN  access address.
- memWdata  output  WORD_LEN  write data.
- ifFreeze  output  1  stalls the PC register and IF/ID register.
- ifInstr  output  WORD_LEN  fetched instruction; 0 (NOP) when squashed or not valid.
- ifValid  output  1  ifInstr is a real instruction this cycle.
- dRdata  output  WORD_LEN  load data, valid with dDone.
- dDone  output  1  one-cycle pulse, data access complete.
- dStall  output  1  stalls the pipeline at MEM while dReq is pending and dDone=0.

Behaviour:
- Reset (async, rst=1): state IDLE; memReq, memWe, memAddr, memWdata = 0; ifInstr = 0; ifValid = 0; dDone = 0; dRdata = 0; squash = 0; starveCnt = 0.
- ifFreeze and dStall are combinational from state and inputs. Both are 0 during reset.
- States: IDLE, IF_WAIT, D_WAIT.
- IDLE arbitration (every IDLE cycle; a fetch is always wanted):
  - dReq=1 and starveCnt<STARVE_MAX: grant data, go to D_WAIT, starveCnt++.
  - Otherwise: grant fetch, go to IF_WAIT, starveCnt=0.
  - memReq/memWe/memAddr/memWdata are registered at the grant edge. memAddr=ifAddr for a fetch (memWe=0); memAddr=dAddr for data.
- IF_WAIT:
  - Hold memReq until the cycle memAck=1. memReq drops on the following edge and state returns to IDLE.
  - On that edge: ifInstr=memRdata and ifValid=1, unless squash, in which case ifInstr=0 and ifValid=0. squash clears.
- D_WAIT: on memAck, register dRdata=memRdata (loads only; stores leave dRdata unchanged), pulse dDone=1 for one cycle, return to IDLE.
- ifFreeze = 1 in every cycle where no fetch completes on the next edge, i.e. IDLE, D_WAIT, and IF_WAIT with memAck=0. It is 0 exactly in the IF_WAIT cycle with memAck=1, so PC advances once per fetch.
- brTaken:
  - In IF_WAIT with memAck=0: set squash.
  - In IF_WAIT with memAck=1: that instruction is squashed directly (ifValid=0).
  - In IDLE/D_WAIT: no effect, since the PC loads the target when the next fetch completes.
- Minimum latency: grant edge → memReq; earliest memAck in the same cycle memReq is high → ifValid/dDone on the next edge. A fetch therefore takes 2 cycles minimum (IDLE + IF_WAIT).
- ifValid and dDone are one-cycle pulses and default to 0.
- dReq deasserted mid-D_WAIT is illegal; no recovery is required.
- memAck outside IF_WAIT/D_WAIT is ignored.
- Reset mid-access: abandon immediately; memReq drops asynchronously.

Decomposition:
- Shared defines file: WORD_LEN (existing), state encodings ARB_IDLE/ARB_IF/ARB_D (2 bits), NOP constant 32'd0.
- One sub-module, arb_starve_counter: saturating counter with clear, increment, and output starveCnt>=STARVE_MAX.
- The rest stays in a single FSM module.

Test Plan:
- Fetch only, memAck 1 cycle after memReq, ifAddr=0x00,0x04,0x08 → memAddr follows; ifValid pulses every 3 cycles; ifInstr=memRdata (0xE3A01005 etc.); ifFreeze=0 only in ack cycles.
- Load at dAddr=0x100 raised with the arbiter in IDLE, memRdata=0xDEADBEEF → memWe=0, memAddr=0x100, dDone pulse, dRdata=0xDEADBEEF, dStall=1 until dDone.
- Store dAddr=0x200, dWdata=0x12345678 → memWe=1, memWdata=0x12345678, dDone pulse, dRdata unchanged.
- dReq held high across 3 back-to-back loads with STARVE_MAX=2 → grant order D, D, IF, D; starveCnt clears after the IF grant.
- brTaken pulsed 1 cycle into a 3-cycle fetch of 0x10 → on ack, ifValid=0 and ifInstr=0; next fetch uses the new ifAddr=0x40 and ifValid=1.
- rst asserted while in D_WAIT with memReq=1 → memReq=0, dDone=0, state IDLE immediately; after release, the first grant is a fetch.

Source files
------------

// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared constants and types for the unified-memory fetch/data arbiter.
package fetch_mem_arbiter_pkg;

   localparam int unsigned WORD_LEN       = 32;
   localparam int unsigned DEF_STARVE_MAX = 2;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_IF   = 2'd1;
   localparam logic [1:0] ARB_D    = 2'd2;

   localparam logic [WORD_LEN-1:0] NOP = 32'd0;

   // Command presented on the memory port for one access.
   typedef struct packed {
      logic                we;
      logic [WORD_LEN-1:0] addr;
      logic [WORD_LEN-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the fetch/data arbiter.
interface fetch_mem_arbiter_if;
   import fetch_mem_arbiter_pkg::*;

   logic [WORD_LEN-1:0] ifAddr;
   logic                brTaken;
   logic                dReq;
   logic                dWe;
   logic [WORD_LEN-1:0] dAddr;
   logic [WORD_LEN-1:0] dWdata;
   logic                memAck;
   logic [WORD_LEN-1:0] memRdata;
   logic                memReq;
   logic                memWe;
   logic [WORD_LEN-1:0] memAddr;
   logic [WORD_LEN-1:0] memWdata;
   logic                ifFreeze;
   logic [WORD_LEN-1:0] ifInstr;
   logic                ifValid;
   logic [WORD_LEN-1:0] dRdata;
   logic                dDone;
   logic                dStall;

   // Arbiter side
   modport master (
      input  ifAddr, brTaken, dReq, dWe, dAddr, dWdata, memAck, memRdata,
      output memReq, memWe, memAddr, memWdata, ifFreeze, ifInstr, ifValid,
             dRdata, dDone, dStall
   );

   // Pipeline/memory side
   modport slave (
      output ifAddr, brTaken, dReq, dWe, dAddr, dWdata, memAck, memRdata,
      input  memReq, memWe, memAddr, memWdata, ifFreeze, ifInstr, ifValid,
             dRdata, dDone, dStall
   );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants made while a fetch is waiting.
module arb_starve_counter #(
   parameter int unsigned MAX = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_limit_c
);

   localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CW-1:0] cnt;

   // Saturating count; clear has priority over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       cnt <= '0;
      else if (clr)                  cnt <= '0;
      else if (inc && !at_limit_c)   cnt <= cnt + CW'(1);
   end

   assign at_limit_c = (32'(cnt) >= MAX);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
module fetch_mem_arbiter
   import fetch_mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   fetch_mem_arbiter_if.master bus
);

   logic [1:0]          state, state_nxt;
   logic                squash, squash_nxt;
   mem_cmd_t            cmd, cmd_nxt;
   logic                mem_req, mem_req_nxt;
   logic [WORD_LEN-1:0] if_instr, if_instr_nxt;
   logic                if_valid, if_valid_nxt;
   logic [WORD_LEN-1:0] d_rdata, d_rdata_nxt;
   logic                d_done, d_done_nxt;
   logic                cnt_clr, cnt_inc, starved;
   logic                if_freeze_c;

   arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .at_limit_c (starved)
   );

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         squash   <= 1'b0;
         cmd      <= '0;
         mem_req  <= 1'b0;
         if_instr <= NOP;
         if_valid <= 1'b0;
         d_rdata  <= '0;
         d_done   <= 1'b0;
      end else begin
         state    <= state_nxt;
         squash   <= squash_nxt;
         cmd      <= cmd_nxt;
         mem_req  <= mem_req_nxt;
         if_instr <= if_instr_nxt;
         if_valid <= if_valid_nxt;
         d_rdata  <= d_rdata_nxt;
         d_done   <= d_done_nxt;
      end
   end

   // Arbitration, access sequencing and completion pulses.
   always_comb begin
      state_nxt    = state;
      squash_nxt   = squash;
      cmd_nxt      = cmd;
      mem_req_nxt  = mem_req;
      if_instr_nxt = NOP;
      if_valid_nxt = 1'b0;
      d_rdata_nxt  = d_rdata;
      d_done_nxt   = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      if_freeze_c  = 1'b1;

      case (state)
         ARB_IDLE: begin
            mem_req_nxt = 1'b1;
            if (bus.dReq && !starved) begin
               cmd_nxt   = '{we: bus.dWe, addr: bus.dAddr, wdata: bus.dWdata};
               cnt_inc   = 1'b1;
               state_nxt = ARB_D;
            end else begin
               cmd_nxt   = '{we: 1'b0, addr: bus.ifAddr, wdata: NOP};
               cnt_clr   = 1'b1;
               state_nxt = ARB_IF;
            end
         end
         ARB_IF: begin
            if (bus.memAck) begin
               if_freeze_c = 1'b0;
               mem_req_nxt = 1'b0;
               squash_nxt  = 1'b0;
               state_nxt   = ARB_IDLE;
               // A redirect in the ack cycle kills this instruction directly.
               if (!(squash || bus.brTaken)) begin
                  if_instr_nxt = bus.memRdata;
                  if_valid_nxt = 1'b1;
               end
            end else if (bus.brTaken) begin
               squash_nxt = 1'b1;
            end
         end
         ARB_D: begin
            if (bus.memAck) begin
               mem_req_nxt = 1'b0;
               d_done_nxt  = 1'b1;
               state_nxt   = ARB_IDLE;
               if (!cmd.we) d_rdata_nxt = bus.memRdata;
            end
         end
         default: begin
            mem_req_nxt = 1'b0;
            state_nxt   = ARB_IDLE;
         end
      endcase
   end

   assign bus.memReq   = mem_req;
   assign bus.memWe    = cmd.we;
   assign bus.memAddr  = cmd.addr;
   assign bus.memWdata = cmd.wdata;
   assign bus.ifInstr  = if_instr;
   assign bus.ifValid  = if_valid;
   assign bus.dRdata   = d_rdata;
   assign bus.dDone    = d_done;
   assign bus.ifFreeze = ~rst & if_freeze_c;
   assign bus.dStall   = ~rst & bus.dReq & ~d_done;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed and randomized checks of fetch_mem_arbiter against a transaction-level model.
module tb_fetch_mem_arbiter;
   import fetch_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_mem_arbiter_if bus();

   fetch_mem_arbiter #(.STARVE_MAX(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int errs    = 0;

   // Model: one outstanding access at most, plus starvation tally.
   bit          busy, is_fetch, squash_m, fdone;
   int          starve;
   bit          e_memreq, e_we, e_ifvalid, e_ddone;
   logic [31:0] e_addr, e_wdata, e_ifinstr, e_drdata;

   // Responder and requester knobs.
   bit          use_fixed, rand_mode, hold_dreq, redirect;
   int          ack_wait, cur_wait, age;
   logic [31:0] rdata_val, br_target;
   byte         dut_seq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; is_fetch = 0; squash_m = 0; fdone = 0; starve = 0;
      e_memreq = 0; e_we = 0; e_ifvalid = 0; e_ddone = 0;
      e_addr = '0; e_wdata = '0; e_ifinstr = '0; e_drdata = '0;
      age = 0;
   endtask

   task automatic drive_mem();
      if (bus.memReq) begin
         bus.memAck = (age >= cur_wait);
         age++;
      end else begin
         age      = 0;
         cur_wait = rand_mode ? int'($urandom_range(0, 3)) : ack_wait;
         bus.memAck = rand_mode && ($urandom_range(0, 7) == 0);
      end
      bus.memRdata = use_fixed ? rdata_val : $urandom;
   endtask

   // Check combinational outputs, then predict the next edge.
   task automatic predict();
      bit n_ifvalid, n_ddone;
      logic [31:0] n_ifinstr;
      #1;
      chk("ifFreeze", 32'(bus.ifFreeze), (busy && is_fetch && bus.memAck) ? 32'd0 : 32'd1);
      chk("dStall", 32'(bus.dStall), 32'(bus.dReq && !e_ddone));
      n_ifvalid = 0; n_ddone = 0; n_ifinstr = '0; fdone = 0;
      if (!busy) begin
         if (bus.dReq && starve < 2) begin
            is_fetch = 0; e_we = bus.dWe; e_addr = bus.dAddr; e_wdata = bus.dWdata;
            starve++;
         end else begin
            is_fetch = 1; e_we = 0; e_addr = bus.ifAddr;
            starve = 0;
         end
         busy = 1; e_memreq = 1;
      end else if (bus.memAck) begin
         if (is_fetch) begin
            if (!(squash_m || bus.brTaken)) begin
               n_ifvalid = 1; n_ifinstr = bus.memRdata;
            end
            squash_m = 0; fdone = 1;
         end else begin
            n_ddone = 1;
            if (!e_we) e_drdata = bus.memRdata;
         end
         busy = 0; e_memreq = 0;
      end else if (is_fetch && bus.brTaken) begin
         squash_m = 1;
      end
      e_ifvalid = n_ifvalid; e_ifinstr = n_ifinstr; e_ddone = n_ddone;
   endtask

   task automatic check_regs();
      chk("memReq", 32'(bus.memReq), 32'(e_memreq));
      chk("ifValid", 32'(bus.ifValid), 32'(e_ifvalid));
      chk("ifInstr", bus.ifInstr, e_ifinstr);
      chk("dDone", 32'(bus.dDone), 32'(e_ddone));
      chk("dRdata", bus.dRdata, e_drdata);
      if (e_memreq) begin
         chk("memAddr", bus.memAddr, e_addr);
         chk("memWe", 32'(bus.memWe), 32'(e_we));
         if (e_we) chk("memWdata", bus.memWdata, e_wdata);
      end
      if (bus.ifValid) dut_seq.push_back(8'h46);
      if (bus.dDone)   dut_seq.push_back(8'h44);
   endtask

   // One clock: respond, check, clock, check, then requester reactions.
   task automatic cycle();
      drive_mem();
      predict();
      @(posedge clk);
      #1;
      check_regs();
      if (bus.brTaken) redirect = 1;
      bus.brTaken = 1'b0;
      if (fdone) begin
         bus.ifAddr = redirect ? br_target : bus.ifAddr + 32'd4;
         redirect = 0;
      end
      if (e_ddone && !hold_dreq) bus.dReq = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy; i++) cycle();
      chk("idle_reached", 32'(bus.memReq), 32'd0);
   endtask

   task automatic run_fetch();
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (fdone) break;
      end
      chk("fetch_completed", 32'(fdone), 32'd1);
   endtask

   task automatic run_data();
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (e_ddone) break;
      end
      chk("data_done", 32'(bus.dDone), 32'd1);
   endtask

   logic [31:0] instrs [3] = '{32'hE3A01005, 32'hE2811001, 32'hE1A02001};

   initial begin
      int nd;
      bus.ifAddr = '0; bus.brTaken = 0; bus.dReq = 1'b1; bus.dWe = 0;
      bus.dAddr = '0; bus.dWdata = '0; bus.memAck = 0; bus.memRdata = '0;
      use_fixed = 1; rand_mode = 0; hold_dreq = 0; redirect = 0;
      ack_wait = 1; cur_wait = 1; rdata_val = '0; br_target = '0;
      model_reset();
      rst = 1'b1;

      // Reset values, with a data request pending during reset.
      @(posedge clk); @(posedge clk); #1;
      chk("rst_memReq", 32'(bus.memReq), 32'd0);
      chk("rst_memAddr", bus.memAddr, 32'd0);
      chk("rst_ifValid", 32'(bus.ifValid), 32'd0);
      chk("rst_dDone", 32'(bus.dDone), 32'd0);
      chk("rst_ifFreeze", 32'(bus.ifFreeze), 32'd0);
      chk("rst_dStall", 32'(bus.dStall), 32'd0);
      bus.dReq = 1'b0;
      rst = 1'b0;

      // Straight-line fetches, one-cycle ack delay.
      for (int k = 0; k < 3; k++) begin
         rdata_val = instrs[k];
         cycle();
         chk("fetch_addr", bus.memAddr, 32'(k * 4));
         cycle();
         cycle();
         chk("fetch_instr", bus.ifInstr, instrs[k]);
         chk("fetch_valid", 32'(bus.ifValid), 32'd1);
      end

      // Load.
      bus.dReq = 1; bus.dWe = 0; bus.dAddr = 32'h100; rdata_val = 32'hDEADBEEF;
      cycle();
      chk("load_we", 32'(bus.memWe), 32'd0);
      chk("load_addr", bus.memAddr, 32'h100);
      run_data();
      chk("load_rdata", bus.dRdata, 32'hDEADBEEF);
      wait_idle();

      // Store leaves dRdata unchanged.
      bus.dReq = 1; bus.dWe = 1; bus.dAddr = 32'h200; bus.dWdata = 32'h12345678;
      rdata_val = 32'hCAFEF00D;
      cycle();
      chk("store_we", 32'(bus.memWe), 32'd1);
      chk("store_wdata", bus.memWdata, 32'h12345678);
      run_data();
      chk("store_rdata_kept", bus.dRdata, 32'hDEADBEEF);

      // Back-to-back loads: expect D, D, IF, D.
      run_fetch();
      wait_idle();
      ack_wait = 0; hold_dreq = 1; nd = 0;
      dut_seq.delete();
      bus.dReq = 1; bus.dWe = 0; bus.dAddr = 32'h300; rdata_val = 32'h0BADF00D;
      for (int i = 0; i < 40 && nd < 3; i++) begin
         cycle();
         if (e_ddone) begin
            nd++;
            bus.dAddr = bus.dAddr + 32'd4;
            if (nd == 2) hold_dreq = 0;
         end
      end
      chk("starve_count", 32'(dut_seq.size()), 32'd4);
      if (dut_seq.size() == 4) begin
         chk("starve_g0", 32'(dut_seq[0]), 32'h44);
         chk("starve_g1", 32'(dut_seq[1]), 32'h44);
         chk("starve_g2", 32'(dut_seq[2]), 32'h46);
         chk("starve_g3", 32'(dut_seq[3]), 32'h44);
      end
      wait_idle();

      // Redirect one cycle into a three-cycle fetch.
      bus.ifAddr = 32'h10; ack_wait = 2; rdata_val = 32'hAAAA5555; br_target = 32'h40;
      cycle();
      chk("br_fetch_addr", bus.memAddr, 32'h10);
      bus.brTaken = 1;
      run_fetch();
      chk("br_squash_valid", 32'(bus.ifValid), 32'd0);
      chk("br_squash_instr", bus.ifInstr, 32'd0);
      rdata_val = 32'h11112222;
      cycle();
      chk("br_target_addr", bus.memAddr, 32'h40);
      run_fetch();
      chk("br_target_valid", 32'(bus.ifValid), 32'd1);
      chk("br_target_instr", bus.ifInstr, 32'h11112222);

      // Redirect in the ack cycle itself.
      ack_wait = 0; br_target = 32'h80;
      cycle();
      bus.brTaken = 1;
      cycle();
      chk("br_ack_valid", 32'(bus.ifValid), 32'd0);
      chk("br_ack_instr", bus.ifInstr, 32'd0);

      // Reset while a load waits on memory.
      ack_wait = 5;
      bus.dReq = 1; bus.dWe = 0; bus.dAddr = 32'h400;
      cycle();
      cycle();
      chk("pre_rst_memReq", 32'(bus.memReq), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_memReq", 32'(bus.memReq), 32'd0);
      chk("async_rst_dDone", 32'(bus.dDone), 32'd0);
      chk("async_rst_dStall", 32'(bus.dStall), 32'd0);
      bus.dReq = 1'b0;
      model_reset();
      redirect = 0;
      @(posedge clk); #3 rst = 1'b0;
      bus.ifAddr = 32'h80;
      cycle();
      chk("post_rst_grant_we", 32'(bus.memWe), 32'd0);
      chk("post_rst_grant_addr", bus.memAddr, 32'h80);
      run_fetch();

      // Randomized traffic.
      use_fixed = 0; rand_mode = 1; hold_dreq = 0;
      for (int i = 0; i < 600; i++) begin
         if (!bus.dReq && $urandom_range(0, 2) == 0) begin
            bus.dReq   = 1'b1;
            bus.dWe    = 1'($urandom_range(0, 1));
            bus.dAddr  = $urandom & 32'hFFFF_FFFC;
            bus.dWdata = $urandom;
         end
         if ($urandom_range(0, 9) == 0) begin
            bus.brTaken = 1'b1;
            br_target   = $urandom & 32'hFFFF_FFFC;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
